// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared opcodes, state encoding and select codes for the nRISC control unit
package nrisc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_LI_WB    = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

    localparam logic [1:0] ALUA_PC   = 2'b00;
    localparam logic [1:0] ALUA_REG  = 2'b01;
    localparam logic [1:0] ALUA_ZERO = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_ONE    = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_OFFSET = 2'b11;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_IMM    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_PASSB = 2'b10;

    typedef struct packed {
        logic [1:0] sel_pc;
        logic [1:0] sel_alu_a;
        logic [1:0] sel_alu_b;
        logic [1:0] sel_wb;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/nrisc_multicycle_control_if.sv
// rtl/nrisc_multicycle_control_if.sv - control unit <-> datapath/memory signal bundle
interface nrisc_multicycle_control_if #(
    parameter int OPW  = 3,
    parameter int CNTW = 8
);
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ready;
    logic [1:0]      sel_pc;
    logic [1:0]      sel_alu_a;
    logic [1:0]      sel_alu_b;
    logic [1:0]      sel_wb;
    logic [1:0]      alu_op;
    logic            pc_write;
    logic            pc_write_cond;
    logic            ir_write;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            halted;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output sel_pc, sel_alu_a, sel_alu_b, sel_wb, alu_op,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
        output halted, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  sel_pc, sel_alu_a, sel_alu_b, sel_wb, alu_op,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
        input  halted, instr_count
    );
endinterface

// File: rtl/nrisc_control_decode.sv
// rtl/nrisc_control_decode.sv - combinational state to datapath-control decode
module nrisc_control_decode
    import nrisc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [2:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.sel_pc    = PC_SRC_ALU;
        ctrl.sel_alu_a = ALUA_PC;
        ctrl.sel_alu_b = ALUB_REG;
        ctrl.sel_wb    = WB_ALUOUT;
        ctrl.alu_op    = ALUOP_ADD;
        case (state)
            ST_FETCH: begin
                // PC and IR only latch once the instruction word is actually present
                ctrl.mem_read  = 1'b1;
                ctrl.sel_alu_b = ALUB_ONE;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.sel_alu_b = ALUB_OFFSET;
            end
            ST_EXEC_R: begin
                ctrl.sel_alu_a = ALUA_REG;
                ctrl.alu_op    = (opcode == OP_SUB) ? ALUOP_SUB : ALUOP_ADD;
            end
            ST_WB_R: begin
                ctrl.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.sel_alu_a = ALUA_REG;
                ctrl.sel_alu_b = ALUB_IMM;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.sel_wb    = WB_MDR;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.sel_alu_a     = ALUA_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.sel_pc        = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.sel_pc   = PC_SRC_JUMP;
            end
            ST_LI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.sel_wb    = WB_IMM;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
                ctrl.sel_pc = PC_SRC_HOLD;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/nrisc_multicycle_control.sv
// rtl/nrisc_multicycle_control.sv - nRISC multicycle control FSM with retired-instruction counter
module nrisc_multicycle_control
    import nrisc_pkg::*;
#(
    parameter int OPW  = 3,
    parameter int CNTW = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    nrisc_multicycle_control_if.master bus
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] instr_count_q, instr_count_d;
    logic [2:0]      op;
    logic            retire;
    ctrl_t           ctrl;

    assign op = bus.opcode[2:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RST;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB: state_d = ST_EXEC_R;
                    OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
                    OP_BEQ:         state_d = ST_BRANCH;
                    OP_JMP:         state_d = ST_JUMP;
                    OP_LI:          state_d = ST_LI_WB;
                    default: begin
                        // HALT retires as it is entered since HALT itself never leaves
                        state_d = ST_HALT;
                        retire  = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_MEM_ADDR: state_d = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (bus.mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_WB_R, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_LI_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + CNTW'(1);
    end

    nrisc_control_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .opcode    (op),
        .ctrl      (ctrl)
    );

    assign bus.sel_pc        = ctrl.sel_pc;
    assign bus.sel_alu_a     = ctrl.sel_alu_a;
    assign bus.sel_alu_b     = ctrl.sel_alu_b;
    assign bus.sel_wb        = ctrl.sel_wb;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.halted        = ctrl.halted;
    assign bus.instr_count   = instr_count_q;

endmodule

// File: doc/nrisc_multicycle_control.md
Name: nrisc_multicycle_control

Overview:
- Multicycle control unit of the nRISC 8-bit core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every 2-bit datapath select, which feeds the controle input of the 4:1 8-bit selectors, plus all register and memory enables.
- Sits between the instruction register opcode field and the datapath selectors.
- Handshakes with a variable-latency memory.

Parameters:
- OPW, 3, opcode width (opcode = instruction[7:5]).
- CNTW, 8, retired-instruction counter width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[7:5]; sampled only in DECODE.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- sel_pc  output  2  PC source: 00 ALU result (PC+1), 01 ALUOut (branch target), 10 jump target, 11 hold.
- sel_alu_a  output  2  ALU A: 00 PC, 01 reg A, 10 zero, 11 unused (drive 00).
- sel_alu_b  output  2  ALU B: 00 reg B, 01 constant 1, 10 sign-extended imm, 11 branch offset.
- sel_wb  output  2  register write data: 00 ALUOut, 01 MDR, 10 zero-extended imm, 11 unused.
- alu_op  output  2  00 add, 01 sub, 10 pass B, 11 unused.
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  output  1 each  enables.
- halted  output  1  core stopped.
- instr_count  output  CNTW  retired-instruction count.

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 LW, 011 SW, 100 BEQ, 101 JMP, 110 LI, 111 HALT.
- States: RST, FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, LI_WB, HALT.
- Asynchronous reset behaviour:
  - state <= RST; instr_count <= 0.
  - All outputs are 0 in RST (selects 00, enables 0, halted 0).
  - RST -> FETCH unconditionally on the next edge.
- Outputs are Moore (decoded from state), except pc_write and ir_write in FETCH, which are gated by mem_ready.
- FETCH:
  - Outputs: mem_read=1, sel_alu_a=00, sel_alu_b=01, alu_op=00, sel_pc=00.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE:
  - Outputs: sel_alu_a=00, sel_alu_b=11, alu_op=00 (precompute branch target into ALUOut).
  - Dispatch on opcode: ADD/SUB -> EXEC_R; LW/SW -> MEM_ADDR; BEQ -> BRANCH; JMP -> JUMP; LI -> LI_WB; HALT -> HALT.
- EXEC_R:
  - Outputs: sel_alu_a=01, sel_alu_b=00, alu_op=00 (ADD) or 01 (SUB); opcode is held in the IR.
  - -> WB_R.
- WB_R: reg_write=1, sel_wb=00 -> FETCH.
- MEM_ADDR: sel_alu_a=01, sel_alu_b=10, alu_op=00 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1; wait for mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, sel_wb=01 -> FETCH.
- MEM_WR: mem_write=1; wait for mem_ready -> FETCH.
- BRANCH:
  - Outputs: sel_alu_a=01, sel_alu_b=00, alu_op=01, pc_write_cond=1, sel_pc=01.
  - The datapath loads PC when zero=1.
  - -> FETCH.
- JUMP: pc_write=1, sel_pc=10 -> FETCH.
- LI_WB: reg_write=1, sel_wb=10 -> FETCH.
- HALT: halted=1, sel_pc=11, all enables 0; stays until reset.
- instr_count:
  - Increments by 1 on the edge leaving each final state (WB_R, WB_MEM, MEM_WR on mem_ready, BRANCH, JUMP, LI_WB).
  - Also increments once on entry to HALT.
  - Wraps modulo 2^CNTW.
- Boundary conditions:
  - mem_ready held 0 keeps the current memory state with its outputs stable indefinitely.
  - mem_ready=1 in a non-memory state is ignored.
  - reset asserted mid-instruction forces RST immediately (asynchronous) and suppresses all enables in that same cycle.
  - mem_write and reg_write are never asserted together.
  - Unused select codes are never driven.

Decomposition:
- Shared package nrisc_pkg holds:
  - opcode constants (OP_ADD..OP_HALT);
  - state encoding (4-bit localparams);
  - select-code constants (PC_SRC_*, ALUA_*, ALUB_*, WB_*, ALUOP_*).
- One natural sub-module: nrisc_control_decode, a purely combinational state -> output decode.
- The parent holds the state register, next-state logic and instr_count.

Test Plan:
- Reset:
  - Assert reset mid-MEM_RD.
  - -> all outputs 0 immediately, instr_count=0; FETCH one cycle after release.
- ADD, mem_ready=1 always:
  - Sequence FETCH, DECODE, EXEC_R, WB_R (4 cycles); alu_op=00 in EXEC_R.
  - reg_write=1 and sel_wb=00 in WB_R; instr_count 0->1.
- LW with mem_ready low 3 cycles in both FETCH and MEM_RD:
  - ir_write pulses once on the ready cycle.
  - mem_read stays 1 for 4 cycles in MEM_RD; total 11 cycles.
  - WB_MEM sel_wb=01.
- BEQ:
  - In BRANCH, zero=1: pc_write_cond=1, sel_pc=01.
  - Repeat with zero=0: same outputs, and the next state is FETCH in both cases.
- SW then LI then JMP:
  - mem_write only in MEM_WR; LI_WB sel_wb=10; JUMP sel_pc=10, pc_write=1.
  - instr_count=3 at the end.
- HALT with instr_count=255:
  - -> HALT, halted=1, instr_count wraps to 0.
  - No enables asserted for 20 further cycles.
